// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: ALU operands/control plus memory and writeback controls.
// Latency: none (wires only); the producer registers every signal.
// Backpressure: out_valid/out_ready; the producer holds the bundle while out_ready is low.
// Ports: master = decode stage (drives bundle, samples out_ready); slave = ALU/later stages.
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [3:0]      alu_ctrl;
  logic            branch;
  logic            jump;
  logic            jalr;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [2:0]      mem_funct3;
  logic            illegal;

  modport master (
    output out_valid, op1, op2, alu_ctrl, branch, jump, jalr, imm, out_pc,
           store_data, rs1_val, rd, reg_write, mem_read, mem_write, mem_funct3, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, op1, op2, alu_ctrl, branch, jump, jalr, imm, out_pc,
           store_data, rs1_val, rd, reg_write, mem_read, mem_write, mem_funct3, illegal,
    output out_ready
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode/issue: decodes in_instr, reads the regfile with writeback bypass, registers the bundle.
// Latency: 1 cycle from accepted instruction to out_valid; full throughput of one per cycle.
// Backpressure: in_ready = !out_valid || out_ready; bundle holds while stalled; flush kills held and incoming.
// Ports: clk/rst_n; in_* instruction handshake; rs*_addr/rs*_data regfile read; wb_* bypass; flush; ex = bundle.
module id_ex_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  id_ex_stage_if.master   ex
);
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f;
  assign opcode   = in_instr[6:0];
  assign rd_f     = in_instr[11:7];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  // Immediates, sign-extended from instr[31] through a signed size cast.
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
  // Shift-immediates carry only the 5-bit shift amount; the upper field is funct7.
  assign shamt = XLEN'(in_instr[24:20]);

  // Writeback bypass: a same-cycle write wins over the stale regfile read; x0 reads 0.
  logic [XLEN-1:0] rs1_v, rs2_v;
  assign rs1_v = (rs1_addr == 5'd0) ? '0 :
                 (wb_we && wb_rd == rs1_addr) ? wb_data : rs1_data;
  assign rs2_v = (rs2_addr == 5'd0) ? '0 :
                 (wb_we && wb_rd == rs2_addr) ? wb_data : rs2_data;

  logic [XLEN-1:0] d_op1, d_op2, d_imm;
  logic [3:0]      d_alu;
  logic [2:0]      d_mf3;
  logic            d_branch, d_jump, d_jalr, d_rw, d_mr, d_mw, d_ill;

  always_comb begin
    d_op1    = rs1_v;
    d_op2    = rs2_v;
    d_imm    = '0;
    d_alu    = 4'b0000;
    d_mf3    = 3'b000;
    d_branch = 1'b0;
    d_jump   = 1'b0;
    d_jalr   = 1'b0;
    d_rw     = 1'b0;
    d_mr     = 1'b0;
    d_mw     = 1'b0;
    d_ill    = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_alu = {funct7[5], funct3};
        d_rw  = 1'b1;
        if (funct7 != 7'h00 && funct7 != 7'h20)
          d_ill = 1'b1;
        else if (funct7 == 7'h20 && funct3 != 3'b000 && funct3 != 3'b101)
          d_ill = 1'b1;
      end
      OPC_OPIMM: begin
        d_alu = {1'b0, funct3};
        d_rw  = 1'b1;
        if (funct3 == 3'b001) begin
          d_imm = shamt;
          d_op2 = shamt;
          d_ill = (funct7 != 7'h00);
        end else if (funct3 == 3'b101) begin
          d_imm    = shamt;
          d_op2    = shamt;
          d_alu[3] = in_instr[30];
          // Only bit 30 (SRAI vs SRLI) may be set in the upper field.
          d_ill    = ((funct7 & 7'b101_1111) != 7'h00);
        end else begin
          d_imm = imm_i;
          d_op2 = imm_i;
        end
      end
      OPC_BRANCH: begin
        d_imm    = imm_b;
        d_alu    = {1'b0, funct3};
        d_branch = 1'b1;
        d_ill    = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_LOAD: begin
        d_imm = imm_i;
        d_op2 = imm_i;
        d_mr  = 1'b1;
        d_rw  = 1'b1;
        d_mf3 = funct3;
      end
      OPC_STORE: begin
        d_imm = imm_s;
        d_op2 = imm_s;
        d_mw  = 1'b1;
        d_mf3 = funct3;
      end
      OPC_LUI: begin
        d_imm = imm_u;
        d_op1 = '0;
        d_op2 = imm_u;
        d_rw  = 1'b1;
      end
      OPC_AUIPC: begin
        d_imm = imm_u;
        d_op1 = in_pc;
        d_op2 = imm_u;
        d_rw  = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link address; the target adder uses imm (and rs1_val for JALR).
        d_imm  = (opcode == OPC_JALR) ? imm_i : imm_j;
        d_op1  = in_pc;
        d_op2  = XLEN'(3'd4);
        d_jump = 1'b1;
        d_jalr = (opcode == OPC_JALR);
        d_rw   = 1'b1;
      end
      default: d_ill = 1'b1;
    endcase
    // Illegal bundles still travel downstream but must have no architectural side effect.
    if (d_ill) begin
      d_rw     = 1'b0;
      d_mr     = 1'b0;
      d_mw     = 1'b0;
      d_branch = 1'b0;
      d_jump   = 1'b0;
      d_jalr   = 1'b0;
    end
    if (rd_f == 5'd0)
      d_rw = 1'b0;
  end

  logic            valid_q;
  logic [XLEN-1:0] op1_q, op2_q, imm_q, pc_q, sdata_q, rs1v_q;
  logic [3:0]      alu_q;
  logic [4:0]      rd_q;
  logic [2:0]      mf3_q;
  logic            branch_q, jump_q, jalr_q, rw_q, mr_q, mw_q, ill_q;
  logic            capture;

  assign in_ready = !valid_q || ex.out_ready;
  assign capture  = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      imm_q    <= '0;
      pc_q     <= RESET_PC;
      sdata_q  <= '0;
      rs1v_q   <= '0;
      alu_q    <= 4'b0000;
      rd_q     <= 5'd0;
      mf3_q    <= 3'b000;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
      jalr_q   <= 1'b0;
      rw_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      if (flush)
        valid_q <= 1'b0;
      else if (capture)
        valid_q <= 1'b1;
      else if (ex.out_ready)
        valid_q <= 1'b0;
      if (capture) begin
        op1_q    <= d_op1;
        op2_q    <= d_op2;
        imm_q    <= d_imm;
        pc_q     <= in_pc;
        sdata_q  <= rs2_v;
        rs1v_q   <= rs1_v;
        alu_q    <= d_alu;
        rd_q     <= rd_f;
        mf3_q    <= d_mf3;
        branch_q <= d_branch;
        jump_q   <= d_jump;
        jalr_q   <= d_jalr;
        rw_q     <= d_rw;
        mr_q     <= d_mr;
        mw_q     <= d_mw;
        ill_q    <= d_ill;
      end
    end
  end

  assign ex.out_valid  = valid_q;
  assign ex.op1        = op1_q;
  assign ex.op2        = op2_q;
  assign ex.imm        = imm_q;
  // An empty stage reports RESET_PC rather than the PC of a drained or flushed bundle.
  assign ex.out_pc     = valid_q ? pc_q : RESET_PC;
  assign ex.store_data = sdata_q;
  assign ex.rs1_val    = rs1v_q;
  assign ex.alu_ctrl   = alu_q;
  assign ex.rd         = rd_q;
  assign ex.mem_funct3 = mf3_q;
  assign ex.branch     = branch_q;
  assign ex.jump       = jump_q;
  assign ex.jalr       = jalr_q;
  assign ex.reg_write  = rw_q;
  assign ex.mem_read   = mr_q;
  assign ex.mem_write  = mw_q;
  assign ex.illegal    = ill_q;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-and-issue stage of the RV32I core: the producer side of the ALU control interface.
- Takes a fetched instruction and PC, decodes it, and reads the register file through combinational address/data ports with writeback bypass.
- Registers the ALU operands, alu_ctrl, branch flag and memory/writeback controls into an output pipeline register with valid/ready handshake and flush.
- Output feeds the ALU (op1, op2, alu_ctrl, branch) and the later stages.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC, 32'h0000_0000, value driven on out_pc while the stage is empty.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction and PC valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  32  PC of in_instr.
- rs1_addr  out  5  register file read address 1 (combinational from in_instr[19:15]).
- rs2_addr  out  5  register file read address 2 (in_instr[24:20]).
- rs1_data  in  32  register file read data 1.
- rs2_data  in  32  register file read data 2.
- wb_we  in  1  writeback write enable.
- wb_rd  in  5  writeback destination.
- wb_data  in  32  writeback data.
- flush  in  1  kill the held instruction and the incoming one.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- op1  out  32  ALU operand 1.
- op2  out  32  ALU operand 2.
- alu_ctrl  out  4  ALU operation code.
- branch  out  1  conditional branch; ALU zero output = taken.
- jump  out  1  JAL or JALR.
- jalr  out  1  JALR (target = rs1+imm, else pc+imm).
- imm  out  32  sign-extended immediate.
- out_pc  out  32  PC of the bundle.
- store_data  out  32  rs2 value, bypassed.
- rs1_val  out  32  rs1 value, bypassed (JALR target).
- rd  out  5  destination register.
- reg_write  out  1  write rd (forced 0 when rd==0).
- mem_read  out  1  load.
- mem_write  out  1  store.
- mem_funct3  out  3  load/store width and sign.
- illegal  out  1  unsupported opcode or funct.

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid=0.
  - op1, op2, imm, store_data, rs1_val = 0.
  - alu_ctrl=0, rd=0, mem_funct3=0.
  - all flags 0.
  - out_pc=RESET_PC.
- in_ready = !out_valid || out_ready, combinational.
- Capture on clk when in_valid && in_ready && !flush.
- Latency: 1 cycle.
- Holding: with out_valid && !out_ready, all outputs hold stable.
- Drain: out_valid clears when out_ready is high and nothing is captured.
- flush: out_valid=0 next cycle and no capture, regardless of out_ready. Other output registers may keep stale values.
- Bypass: use wb_data instead of rsN_data when wb_we && wb_rd==rsN_addr && wb_rd!=0. x0 always reads 0.
- Immediates (I/S/B/U/J) per RV32I, sign-extended from bit 31.
- alu_ctrl and operand encoding:
  - OP (0110011): op1=rs1, op2=rs2, alu_ctrl={funct7[5],funct3}.
    - funct7 other than 0x00/0x20 -> illegal.
    - funct7=0x20 only legal with funct3 000/101.
  - OP-IMM (0010011): op2=imm, alu_ctrl={0,funct3}.
    - For funct3=101, alu_ctrl[3]=instr[30].
    - SLLI/SRLI/SRAI with any other instr[31:25] bits set -> illegal.
  - BRANCH (1100011): branch=1, op1=rs1, op2=rs2, alu_ctrl={0,funct3}.
    - funct3 010/011 -> illegal.
  - LOAD (0000011): op1=rs1, op2=imm, ADD (0000), mem_read=1, reg_write=1.
  - STORE (0100011): op1=rs1, op2=S-imm, ADD, mem_write=1.
  - LUI: op1=0, op2=imm, ADD.
  - AUIPC: op1=pc, op2=imm, ADD.
  - JAL/JALR: op1=pc, op2=4, ADD, jump=1, reg_write=1. jalr=1 for JALR.
- illegal=1 forces reg_write, mem_read, mem_write, branch and jump to 0. Bundle still valid so the exception reaches downstream.
- Simultaneous events:
  - out_ready and capture in the same cycle: the new bundle replaces the old one. No bubble; full throughput of 1/cycle.
  - flush with in_valid: the incoming instruction is dropped.

Test Plan:
- Reset mid-stream: assert rst_n=0 while out_valid=1 -> out_valid=0, out_pc=RESET_PC immediately, without a clock edge.
- SUB x3,x1,x2 (0x402081B3), rs1_data=7, rs2_data=5, out_ready=1 -> next cycle: op1=7, op2=5, alu_ctrl=4'b1000, rd=3, reg_write=1.
- SRAI x5,x6,3 (0x40335293) -> alu_ctrl=4'b1101, op2=3. BLTU (funct3=110) -> branch=1, alu_ctrl=4'b0110, imm is the sign-extended B offset.
- Bypass: wb_we=1, wb_rd=1, wb_data=0xDEAD, rs1_data=0 for ADD x4,x1,x0 -> op1=0xDEAD, op2=0. Same with wb_rd=0 -> op1=rs1_data.
- Backpressure:
  - out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable.
  - Raise out_ready -> in_ready=1 and the next instruction is captured that cycle.
  - flush while stalled -> out_valid=0 next cycle.
- Illegal: opcode 0x7F, or OP with funct7=0x01 -> illegal=1, reg_write=0, mem_write=0, out_valid=1.
